plot_sample_scheduler: RTL and testbench
========================================

// Module: plot_sample_scheduler
// PURPOSE
//  Upstream feeder for the graph plotter. Accepts 1-bit samples over a valid/ready
//  handshake and buffers them in a small FIFO. Issues each sample to the plotter as
//  a single-cycle newdata pulse, with plotcoord/plotdata held stable.
//  Columns are assigned in scrolling order (0,1,..,N-1,0,..). Pulses are spaced by
//  at least MIN_GAP idle cycles. Optionally, no write is issued into the column the
//  plotter is currently scanning out.
// PARAMETERS
//  COORD_W      2  column index width; number of columns N = 2**COORD_W
//  FIFO_DEPTH   4  sample FIFO entries (power of 2, >=2)
//  MIN_GAP      2  idle cycles forced after each newdata pulse (0 = back-to-back allowed)
//  AVOID_ACTIVE 1  1: hold issue while target column == current_column_i; 0: ignore
// PORTS
//  clk_i             in   1                       system clock, rising edge
//  rst_i             in   1                       reset, asynchronous, active-high
//  clear_i           in   1                       sync flush: empty FIFO, column ptr to 0
//  sample_valid_i    in   1                       source has a sample
//  sample_data_i     in   1                       sample value (pixel on/off)
//  sample_ready_o    out  1                       FIFO can accept this cycle
//  current_column_i  in   COORD_W                 column being scanned by plotter
//  plotcoord_o       out  COORD_W                 target column of issued sample
//  plotdata_o        out  1                       issued sample value
//  newdata_o         out  1                       1-cycle strobe, plotcoord/plotdata valid
//  fifo_level_o      out  $clog2(FIFO_DEPTH+1)    entries currently stored
//  busy_o            out  1                       FSM not in IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (rst_i=1, async): FSM=IDLE, FIFO empty, col_ptr=0, gap counter=0.
//   Outputs: newdata_o=0, plotcoord_o=0, plotdata_o=0, fifo_level_o=0, busy_o=0.
//   sample_ready_o is forced 0 while rst_i=1.
//  Handshake: sample_ready_o = !full && !clear_i. Push on a rising edge when valid&&ready.
//   sample_valid_i/data are ignored when ready=0; the source must hold them.
//  Full: when fifo_level==FIFO_DEPTH, ready=0, even if a pop occurs in the same cycle.
//  Empty: no issue; FSM stays IDLE.
//  Simultaneous push and pop (non-full): level unchanged, order preserved (FIFO).
//  FSM (all outputs registered):
//   IDLE : FIFO non-empty -> HOLD if AVOID_ACTIVE && col_ptr==current_column_i,
//          else ISSUE
//   HOLD : re-check every cycle; go to ISSUE once col_ptr!=current_column_i
//   ISSUE: newdata_o=1 for exactly this cycle; plotcoord_o=col_ptr, plotdata_o=FIFO head.
//          Pop head; col_ptr<=col_ptr+1 mod N (N-1 wraps to 0).
//          -> GAP with counter=MIN_GAP if MIN_GAP>0, else IDLE
//   GAP  : count down each cycle; at 0 -> IDLE
//  With MIN_GAP=0 and no hold, a continuous stream issues 1 pulse per 2 cycles
//   (ISSUE, IDLE alternating).
//  plotcoord_o/plotdata_o hold the last issued values between pulses (never X).
//  Latency: sample pushed on edge k into an empty FIFO with FSM in IDLE ->
//   newdata_o high between edges k+2 and k+3 (no hold).
//  clear_i=1 (sync, priority over push and issue): on next edge FIFO empty, col_ptr=0,
//   FSM=IDLE, newdata_o=0. plotcoord_o/plotdata_o keep their values.
//  Reset mid-operation: all state is discarded immediately; any in-flight pulse is cut.
//  fifo_level_o is the registered count; it updates on the edge of the push/pop.
// TESTING
//  1 Reset: rst_i=1 mid-ISSUE -> newdata_o=0 immediately, ready=0 during reset,
//    ready=1 first cycle after release, level=0.
//  2 Single sample: push data=1, current_column_i=3, MIN_GAP=2 -> newdata_o pulses
//    2 cycles later with coord=0, data=1; level returns to 0.
//  3 Scroll/wrap: push 5 samples 1,0,1,1,0 (current_column_i held away) -> coords
//    0,1,2,3,0 with matching data, pulse spacing >= 3 cycles (1 ISSUE + 2 GAP).
//  4 Full: stall pops with current_column_i==col_ptr, push 5 -> 4 accepted, ready=0,
//    level=4; release -> all 4 issued in order.
//  5 Hold: col_ptr=2, current_column_i=2 for 10 cycles -> no pulse; change to 3 ->
//    pulse within 2 cycles with coord=2.
//  6 Clear: 3 queued, assert clear_i 1 cycle -> level=0, no further pulses;
//    next sample issues at coord=0.

Source files
------------

// File: rtl/plot_sample_scheduler.sv
`timescale 1ns/1ps
// plot_sample_scheduler
//   Upstream feeder for the graph plotter. Buffers 1-bit samples arriving on a
//   valid/ready handshake in a small FIFO and hands each one to the plotter as a
//   single-cycle newdata pulse. Columns are assigned in scrolling order, pulses
//   are spaced by a minimum idle gap, and (optionally) no write is issued into
//   the column the plotter is currently scanning out.
//
// Ports
//   clk_i            system clock, rising edge
//   rst_i            asynchronous active-high reset
//   clear_i          synchronous flush: FIFO emptied, column pointer to 0
//   sample_valid_i   source has a sample
//   sample_data_i    sample value (pixel on/off)
//   sample_ready_o   FIFO can accept a sample this cycle
//   current_column_i column currently scanned by the plotter
//   plotcoord_o      target column of the issued sample
//   plotdata_o       issued sample value
//   newdata_o        one-cycle strobe, plotcoord_o/plotdata_o valid
//   fifo_level_o     number of stored samples (registered)
//   busy_o           FSM not idle or FIFO non-empty
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a buffered sample
// HOLD  | sample waiting, target column is being scanned; re-check each cycle
// ISSUE | pop head, register pulse/coord/data, advance column pointer
// GAP   | forced idle cycles after a pulse (MIN_GAP of them)

module plot_sample_scheduler #(
  parameter int COORD_W      = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int MIN_GAP      = 2,
  parameter int AVOID_ACTIVE = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic                              sample_valid_i,
  input  logic                              sample_data_i,
  output logic                              sample_ready_o,
  input  logic [COORD_W-1:0]                current_column_i,
  output logic [COORD_W-1:0]                plotcoord_o,
  output logic                              plotdata_o,
  output logic                              newdata_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o,
  output logic                              busy_o
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_ISSUE = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [FIFO_DEPTH-1:0] mem;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level;
  logic [COORD_W-1:0]  col_ptr;
  logic [GW-1:0]       gap_cnt;

  logic                full, empty, push, pop, hold_cond;
  logic                newdata_d, plotdata_d;
  logic [COORD_W-1:0]  plotcoord_d;

  // ------------------------------------------------------------------
  // FIFO
  // ------------------------------------------------------------------
  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);

  // Readiness depends only on the registered level, so a pop in the same
  // cycle never opens a full FIFO.
  assign sample_ready_o = !rst_i && !full && !clear_i;
  assign push           = sample_valid_i && sample_ready_o;
  assign pop            = (state == S_ISSUE) && !clear_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sample_data_i;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign fifo_level_o = level;

  // ------------------------------------------------------------------
  // Column pointer: advances once per issued sample, wraps naturally
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_ptr <= '0;
    end else if (clear_i) begin
      col_ptr <= '0;
    end else if (pop) begin
      col_ptr <= col_ptr + COORD_W'(1);
    end
  end

  assign hold_cond = (AVOID_ACTIVE != 0) && (col_ptr == current_column_i);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (clear_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            state_nxt = hold_cond ? S_HOLD : S_ISSUE;
          end
        end
        S_HOLD: begin
          if (!hold_cond) begin
            state_nxt = S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_nxt = (MIN_GAP > 0) ? S_GAP : S_IDLE;
        end
        S_GAP: begin
          // Leave on the last gap cycle so exactly MIN_GAP cycles are spent here.
          if (gap_cnt <= GW'(1)) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Gap down-counter, loaded while issuing, decremented in GAP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gap_cnt <= '0;
    end else if (clear_i) begin
      gap_cnt <= '0;
    end else if (state == S_ISSUE) begin
      gap_cnt <= GW'(MIN_GAP);
    end else if ((state == S_GAP) && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end

  // ------------------------------------------------------------------
  // FSM: outputs (computed here, registered below)
  // ------------------------------------------------------------------
  always_comb begin
    newdata_d   = 1'b0;
    plotcoord_d = plotcoord_o;
    plotdata_d  = plotdata_o;
    if (pop) begin
      newdata_d   = 1'b1;
      plotcoord_d = col_ptr;
      plotdata_d  = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      newdata_o   <= 1'b0;
      plotcoord_o <= '0;
      plotdata_o  <= 1'b0;
    end else begin
      newdata_o   <= newdata_d;
      plotcoord_o <= plotcoord_d;
      plotdata_o  <= plotdata_d;
    end
  end

  assign busy_o = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_plot_sample_scheduler.sv
`timescale 1ns/1ps
module tb_plot_sample_scheduler;

  localparam int COORD_W = 2;
  localparam int N       = 4;
  localparam int DEPTH   = 4;
  localparam int MIN_GAP = 2;
  localparam int AVOID   = 1;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               clear_i = 1'b0;
  logic               sample_valid_i = 1'b0;
  logic               sample_data_i = 1'b0;
  logic               sample_ready_o;
  logic [COORD_W-1:0] current_column_i = '0;
  logic [COORD_W-1:0] plotcoord_o;
  logic               plotdata_o;
  logic               newdata_o;
  logic [2:0]         fifo_level_o;
  logic               busy_o;

  plot_sample_scheduler #(
    .COORD_W(COORD_W), .FIFO_DEPTH(DEPTH), .MIN_GAP(MIN_GAP), .AVOID_ACTIVE(AVOID)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .sample_valid_i(sample_valid_i), .sample_data_i(sample_data_i),
    .sample_ready_o(sample_ready_o), .current_column_i(current_column_i),
    .plotcoord_o(plotcoord_o), .plotdata_o(plotdata_o), .newdata_o(newdata_o),
    .fifo_level_o(fifo_level_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queue of accepted samples, scrolling column, pulse history.
  bit   q[$];
  int   m_col = 0;
  int   last_coord = 0;
  int   last_data = 0;
  int   edge_no = 0;
  int   last_pulse = -100;
  bit   mon_en = 1'b0;
  bit   hist_ok = 1'b0;
  bit   track_cc = 1'b0;
  logic [COORD_W-1:0] cc_d1;

  // Inputs as the DUT sees them at the next rising edge.
  logic c_valid, c_data, c_clear, c_ready;
  logic [COORD_W-1:0] c_cc;

  always @(negedge clk_i) begin
    c_valid = sample_valid_i;
    c_data  = sample_data_i;
    c_clear = clear_i;
    c_ready = sample_ready_o;
    c_cc    = current_column_i;
  end

  always @(posedge clk_i) begin
    #1;
    if (mon_en) begin
      edge_no++;
      check_val("ready", int'(c_ready), int'(!c_clear && (q.size() < DEPTH)));
      if (c_clear) begin
        q.delete();
        m_col = 0;
        check_val("clear_no_pulse", int'(newdata_o), 0);
      end else begin
        if (newdata_o) begin
          check_val("pulse_has_sample", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            bit exp_d;
            exp_d = q.pop_front();
            check_val("pulse_coord", int'(plotcoord_o), m_col);
            check_val("pulse_data", int'(plotdata_o), int'(exp_d));
            last_coord = m_col;
            last_data  = int'(exp_d);
            m_col      = (m_col + 1) % N;
          end
          check_val("pulse_spacing_ok", int'((edge_no - last_pulse) >= MIN_GAP + 1), 1);
          if (AVOID != 0 && hist_ok)
            check_val("avoid_active_col", int'(plotcoord_o != cc_d1), 1);
          last_pulse = edge_no;
        end else begin
          check_val("hold_coord", int'(plotcoord_o), last_coord);
          check_val("hold_data", int'(plotdata_o), last_data);
        end
        if (c_valid && c_ready) q.push_back(c_data);
      end
      check_val("level", int'(fifo_level_o), q.size());
      if (q.size() > 0) check_val("busy", int'(busy_o), 1);
      cc_d1   = c_cc;
      hist_ok = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
    if (track_cc) current_column_i = COORD_W'((m_col + 2) % N);
  endtask

  task automatic model_clear();
    q.delete();
    m_col = 0; last_coord = 0; last_data = 0;
    edge_no = 0; last_pulse = -100; hist_ok = 1'b0;
  endtask

  task automatic release_reset();
    sample_valid_i = 1'b0;
    clear_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_val("ready_after_rst", int'(sample_ready_o), 1);
    check_val("level_after_rst", int'(fifo_level_o), 0);
    model_clear();
    tick();
    mon_en = 1'b1;
  endtask

  task automatic push_one(input bit d, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (sample_ready_o) begin
        sample_valid_i = 1'b1;
        sample_data_i  = d;
        tick();
        sample_valid_i = 1'b0;
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_drain(input string tag, input int limit);
    for (int i = 0; i < limit && q.size() > 0; i++) tick();
    repeat (MIN_GAP + 2) tick();
    check_val(tag, q.size(), 0);
  endtask

  initial begin
    bit ok;
    bit seen;
    bit pat[5];

    // Reset values
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    check_val("rst_ready", int'(sample_ready_o), 0);
    check_val("rst_newdata", int'(newdata_o), 0);
    check_val("rst_level", int'(fifo_level_o), 0);
    check_val("rst_coord", int'(plotcoord_o), 0);
    check_val("rst_data", int'(plotdata_o), 0);
    check_val("rst_busy", int'(busy_o), 0);
    repeat (2) @(posedge clk_i);
    release_reset();

    // Single sample latency: push at edge k, pulse visible after edge k+2
    current_column_i = 2'd3;
    sample_valid_i = 1'b1;
    sample_data_i  = 1'b1;
    tick();
    sample_valid_i = 1'b0;
    check_val("lat_k", int'(newdata_o), 0);
    tick();
    check_val("lat_k1", int'(newdata_o), 0);
    tick();
    check_val("lat_k2", int'(newdata_o), 1);
    check_val("lat_coord", int'(plotcoord_o), 0);
    check_val("lat_data", int'(plotdata_o), 1);
    check_val("lat_level", int'(fifo_level_o), 0);
    tick();
    check_val("lat_one_cycle", int'(newdata_o), 0);
    wait_drain("single_drain", 20);

    // Scroll and wrap from column 0
    mon_en = 1'b0;
    rst_i = 1'b1;
    tick();
    release_reset();
    track_cc = 1'b1;
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0;
    for (int i = 0; i < 5; i++) begin
      push_one(pat[i], 30, ok);
      check_val("scroll_push", int'(ok), 1);
    end
    wait_drain("scroll_drain", 60);
    check_val("scroll_col_wrapped", m_col, 1);

    // Full: block issue by scanning the target column
    track_cc = 1'b0;
    current_column_i = COORD_W'(m_col);
    for (int i = 0; i < 4; i++) begin
      push_one(i[0], 4, ok);
      check_val("full_push", int'(ok), 1);
    end
    push_one(1'b1, 4, ok);
    check_val("full_5th_refused", int'(ok), 0);
    check_val("full_ready", int'(sample_ready_o), 0);
    check_val("full_level", int'(fifo_level_o), 4);
    track_cc = 1'b1;
    wait_drain("full_drain", 60);

    // Hold while column 2 is being scanned
    for (int i = 0; i < 8 && m_col != 2; i++) begin
      push_one(1'b0, 20, ok);
      wait_drain("hold_prep", 30);
    end
    check_val("hold_at_col2", m_col, 2);
    track_cc = 1'b0;
    current_column_i = 2'd2;
    push_one(1'b1, 4, ok);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("hold_no_pulse", int'(newdata_o), 0);
    end
    current_column_i = 2'd3;
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      tick();
      if (newdata_o) begin
        seen = 1'b1;
        check_val("hold_release_coord", int'(plotcoord_o), 2);
      end
    end
    check_val("hold_release_pulse", int'(seen), 1);
    wait_drain("hold_drain", 20);

    // Clear with three samples queued
    current_column_i = COORD_W'(m_col);
    for (int i = 0; i < 3; i++) push_one(1'b1, 4, ok);
    check_val("clr_level_before", int'(fifo_level_o), 3);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check_val("clr_level", int'(fifo_level_o), 0);
    current_column_i = 2'd2;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val("clr_no_pulse", int'(newdata_o), 0);
    end
    push_one(1'b1, 4, ok);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (newdata_o) begin
        seen = 1'b1;
        check_val("clr_next_coord", int'(plotcoord_o), 0);
      end else tick();
    end
    check_val("clr_next_pulse", int'(seen), 1);
    wait_drain("clr_drain", 20);

    // Reset during a pulse
    track_cc = 1'b1;
    push_one(1'b1, 4, ok);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (newdata_o) seen = 1'b1;
      else tick();
    end
    check_val("rst_mid_pulse_seen", int'(seen), 1);
    mon_en = 1'b0;
    rst_i = 1'b1;
    #1;
    check_val("rst_mid_newdata", int'(newdata_o), 0);
    check_val("rst_mid_ready", int'(sample_ready_o), 0);
    check_val("rst_mid_level", int'(fifo_level_o), 0);
    tick();
    release_reset();

    // Randomized traffic against the model
    track_cc = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      clear_i = ($urandom_range(0, 99) == 0);
      if (!(sample_valid_i && !c_ready)) begin
        sample_valid_i = ($urandom_range(0, 1) == 1);
        sample_data_i  = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 3) == 0) current_column_i = COORD_W'($urandom_range(0, N - 1));
      tick();
    end
    clear_i = 1'b0;
    sample_valid_i = 1'b0;
    track_cc = 1'b1;
    tick();
    wait_drain("random_drain", 100);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
